// File: rtl/sipo_reg.sv
// sipo_reg: serial-in parallel-out receiver with a one-word holding register.
// A frame begins with start (sampled in IDLE only); the following n cycles
// with in_valid=1 supply the data bits. The completed word is handed over
// through out/out_valid/out_ready, and is dropped (setting overrun) when
// the holding register is still full.
// Optional build macro SIPO_PARITY_EN adds a trailing even-parity bit per
// frame and a sticky parity_err flag; without it parity_err is tied low.
module sipo_reg #(
    parameter int n         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic         serial_in,
    output logic [n-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);

    localparam int CW = (n > 2) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef SIPO_PARITY_EN
        PARITY = 2'd2,
`endif
        SHIFT  = 2'd1
    } state_t;

    state_t          state;
    logic [n-1:0]    shreg;
    logic [n-1:0]    shnext;
    logic [n-1:0]    word;
    logic [CW-1:0]   cnt;
    logic            last_bit;
    logic            complete;
    logic            accept;

    // Next shift-register value and the completion / commit conditions
    always_comb begin
        shnext   = MSB_FIRST ? {shreg[n-2:0], serial_in} : {serial_in, shreg[n-1:1]};
        last_bit = (state == SHIFT) && in_valid && (cnt == CW'(n - 1));
`ifdef SIPO_PARITY_EN
        // Data is already fully shifted when the parity bit arrives
        complete = (state == PARITY) && in_valid;
        word     = shreg;
`else
        // Commit the word including the bit arriving on this edge
        complete = last_bit;
        word     = shnext;
`endif
        accept   = !out_valid || out_ready;
    end

    // Frame FSM, shift register, holding register and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (in_valid) begin
                        shreg <= shnext;
                        cnt   <= cnt + 1'b1;
                        if (last_bit) begin
                            cnt <= '0;
`ifdef SIPO_PARITY_EN
                            state <= PARITY;
`else
                            state <= IDLE;
                            busy  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    if (in_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (serial_in != ^shreg)
                            parity_err <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A commit in the same edge as a consume refills the register
            if (complete) begin
                if (accept) begin
                    out       <= word;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifndef SIPO_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_reg.sv
// tb_sipo_reg: directed and randomized checks of sipo_reg. Two instances share
// all stimulus, one MSB-first and one LSB-first, and are compared against a
// frame-level reference model that collects bits in a queue.
module tb_sipo_reg;

    localparam int N = 8;
`ifdef SIPO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic         serial_in;
    logic         out_ready;
    logic [N-1:0] out_m, out_l;
    logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, perr_m, perr_l;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit           m_busy, m_valid, m_ovr, m_perr;
    logic [N-1:0] m_out_m, m_out_l;
    bit           q[$];

    always #5 clk = ~clk;

    sipo_reg #(.n(N), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .serial_in(serial_in), .out(out_m), .out_valid(valid_m),
        .out_ready(out_ready), .busy(busy_m), .overrun(ovr_m), .parity_err(perr_m)
    );

    sipo_reg #(.n(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .serial_in(serial_in), .out(out_l), .out_valid(valid_l),
        .out_ready(out_ready), .busy(busy_l), .overrun(ovr_l), .parity_err(perr_l)
    );

    function automatic void model_reset();
        m_busy = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
        m_out_m = '0; m_out_l = '0;
        q.delete();
    endfunction

    // Predict the effect of the coming rising edge from the current inputs
    function automatic void model_step();
        bit done = 0;
        logic [N-1:0] wm = '0;
        logic [N-1:0] wl = '0;
        if (!m_busy) begin
            if (start) begin
                m_busy = 1;
                q.delete();
            end
        end else if (in_valid) begin
            q.push_back(serial_in);
            if (q.size() == N + PB) begin
                done   = 1;
                m_busy = 0;
            end
        end
        if (done) begin
            for (int i = 0; i < N; i++) begin
                wm[N-1-i] = q[i];
                wl[i]     = q[i];
            end
`ifdef SIPO_PARITY_EN
            if (q[N] != (^wm)) m_perr = 1;
`endif
            if (!m_valid || out_ready) begin
                m_out_m = wm;
                m_out_l = wl;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Drive one frame; optional idle gap after bit gap_at, optional out_ready on the completing bit
    task automatic drive_frame(input logic [N-1:0] w, input int gap_at, input int gap_len,
                               input bit par, input bit rdy_last);
        bit saved;
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < N + PB; i++) begin
            in_valid  = 1'b1;
            serial_in = (i < N) ? w[N-1-i] : par;
            saved     = out_ready;
            if (rdy_last && i == N + PB - 1) out_ready = 1'b1;
            tick();
            out_ready = saved;
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_m, out_l, valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, perr_m, perr_l} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got out=%h/%h valid=%b%b busy=%b%b ovr=%b%b perr=%b%b, want all 0",
                     out_m, out_l, valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, perr_m, perr_l);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [N-1:0] w = 8'hAB;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid  = 1'b1;
            serial_in = w[N-1-i];
            tick();
            if (i == N - 2) begin
                n_cmp++;
                if (valid_m !== 1'b0 || busy_m !== 1'b1) begin
                    n_bad++;
                    $display("FAIL single_before_last: valid=%b busy=%b, want valid=0 busy=1", valid_m, busy_m);
                end
            end
        end
`ifdef SIPO_PARITY_EN
        serial_in = ^w;
        tick();
`endif
        in_valid = 1'b0;
        n_cmp++;
        if (out_m !== 8'hAB || out_l !== 8'hD5 || valid_m !== 1'b1 || busy_m !== 1'b0) begin
            n_bad++;
            $display("FAIL single_frame: out=%h lsb=%h valid=%b busy=%b, want AB D5 1 0",
                     out_m, out_l, valid_m, busy_m);
        end
    endtask

    task automatic test_gaps();
        logic [N-1:0] w = 8'hAB;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid  = 1'b1;
            serial_in = w[N-1-i];
            tick();
            if (i == 1) begin
                in_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    tick();
                    n_cmp++;
                    if (busy_m !== 1'b1 || busy_l !== 1'b1) begin
                        n_bad++;
                        $display("FAIL gap_busy[%0d]: busy=%b%b, want 11", g, busy_m, busy_l);
                    end
                end
            end
        end
`ifdef SIPO_PARITY_EN
        serial_in = ^w;
        tick();
`endif
        in_valid = 1'b0;
        n_cmp++;
        if (out_l !== 8'hD5 || out_m !== 8'hAB || valid_l !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_frame: lsb=%h msb=%h valid=%b, want D5 AB 1", out_l, out_m, valid_l);
        end
    endtask

    task automatic test_overrun();
        pulse_reset();
        out_ready = 1'b0;
        drive_frame(8'hAB, -1, 0, ^8'hAB, 1'b0);
        drive_frame(8'h3C, -1, 0, ^8'h3C, 1'b0);
        n_cmp++;
        if (out_m !== 8'hAB || ovr_m !== 1'b1 || valid_m !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_drop: out=%h ovr=%b valid=%b, want AB 1 1", out_m, ovr_m, valid_m);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (valid_m !== 1'b0 || out_m !== 8'hAB) begin
            n_bad++;
            $display("FAIL overrun_consume: valid=%b out=%h, want 0 AB", valid_m, out_m);
        end
        drive_frame(8'h55, -1, 0, ^8'h55, 1'b0);
        n_cmp++;
        if (out_m !== 8'h55 || valid_m !== 1'b1 || ovr_m !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_third: out=%h valid=%b ovr=%b, want 55 1 1", out_m, valid_m, ovr_m);
        end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        out_ready = 1'b0;
        drive_frame(8'hAB, -1, 0, ^8'hAB, 1'b0);
        drive_frame(8'h0F, -1, 0, ^8'h0F, 1'b1);
        n_cmp++;
        if (out_m !== 8'h0F || valid_m !== 1'b1 || ovr_m !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_commit: out=%h valid=%b ovr=%b, want 0F 1 0", out_m, valid_m, ovr_m);
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] w = 8'hC3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            serial_in = w[N-1-i];
            tick();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({out_m, out_l, valid_m, busy_m, ovr_m, perr_m} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: out=%h lsb=%h valid=%b busy=%b ovr=%b perr=%b, want all 0",
                     out_m, out_l, valid_m, busy_m, ovr_m, perr_m);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_frame(8'hFF, -1, 0, ^8'hFF, 1'b0);
        n_cmp++;
        if (out_m !== 8'hFF || valid_m !== 1'b1) begin
            n_bad++;
            $display("FAIL after_reset_frame: out=%h valid=%b, want FF 1", out_m, valid_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b;
        pulse_reset();
        out_ready = 1'b1;
        a = N'($urandom);
        b = N'($urandom);
        drive_frame(a, -1, 0, ^a, 1'b0);
        n_cmp++;
        if ({out_m, out_l, valid_m, busy_m} !== {m_out_m, m_out_l, m_valid, m_busy}) begin
            n_bad++;
            $display("FAIL b2b_first: out=%h lsb=%h valid=%b busy=%b, want %h %h %b %b",
                     out_m, out_l, valid_m, busy_m, m_out_m, m_out_l, m_valid, m_busy);
        end
        drive_frame(b, -1, 0, ^b, 1'b0);
        n_cmp++;
        if (out_m !== b || {out_l, valid_m, ovr_m} !== {m_out_l, m_valid, m_ovr}) begin
            n_bad++;
            $display("FAIL b2b_second: out=%h lsb=%h valid=%b ovr=%b, want %h %h %b %b",
                     out_m, out_l, valid_m, ovr_m, b, m_out_l, m_valid, m_ovr);
        end
        out_ready = 1'b0;
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        pulse_reset();
        out_ready = 1'b1;
        drive_frame(8'hAB, -1, 0, 1'b1, 1'b0);
        n_cmp++;
        if (out_m !== 8'hAB || perr_m !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_good: out=%h perr=%b, want AB 0", out_m, perr_m);
        end
        drive_frame(8'hAB, -1, 0, 1'b0, 1'b0);
        n_cmp++;
        if (out_m !== 8'hAB || perr_m !== 1'b1) begin
            n_bad++;
            $display("FAIL parity_bad: out=%h perr=%b, want AB 1", out_m, perr_m);
        end
        out_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 600; c++) begin
            start     = ($urandom_range(3) == 0);
            in_valid  = ($urandom_range(3) != 0);
            serial_in = 1'($urandom);
            out_ready = ($urandom_range(2) == 0);
            tick();
            n_cmp++;
            if ({out_m, out_l, valid_m, valid_l, busy_m, busy_l, ovr_m, perr_m} !==
                {m_out_m, m_out_l, m_valid, m_valid, m_busy, m_busy, m_ovr, m_perr}) begin
                n_bad++;
                $display("FAIL random[%0d]: out=%h lsb=%h valid=%b%b busy=%b%b ovr=%b perr=%b, want %h %h %b %b %b %b",
                         c, out_m, out_l, valid_m, valid_l, busy_m, busy_l, ovr_m, perr_m,
                         m_out_m, m_out_l, m_valid, m_busy, m_ovr, m_perr);
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_frame();
        test_gaps();
        test_overrun();
        test_simultaneous();
        test_async_reset();
        test_back_to_back();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
